// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S transmitter sending one mono sample on both channels, MSB first, one-bclk delay
// Defining I2S_TX_MUTE_EN adds a mute input that latches zero at frame boundaries.
module i2s_tx #(
    parameter int BCLK_DIV = 8,
    parameter int SAMPLE_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
`ifdef I2S_TX_MUTE_EN
    input  logic                mute,
`endif
    input  logic [SAMPLE_W-1:0] sample,
    output logic                sample_req,
    output logic                bclk,
    output logic                lrclk,
    output logic                dacdat
);

    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam int CNT_W = $clog2(2 * SAMPLE_W);
    localparam int IDX_W = $clog2(SAMPLE_W);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SAMPLE_W - 1);
    localparam logic [CNT_W-1:0] CNT_RIGHT = CNT_W'(SAMPLE_W);

    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                bclk_q, bclk_d;
    logic                lrclk_q, lrclk_d;
    logic                dacdat_q, dacdat_d;
    logic                sample_req_q, sample_req_d;
    logic [SAMPLE_W-1:0] hold_q, hold_d;

    logic [SAMPLE_W-1:0] latch_val;
    logic [CNT_W-1:0]    bit_nxt;
    logic [IDX_W-1:0]    slot_idx;
    logic                term_cnt;

`ifdef I2S_TX_MUTE_EN
    assign latch_val = mute ? '0 : sample;
`else
    assign latch_val = sample;
`endif

    assign term_cnt = (div_cnt_q == DIV_LAST);

    // Slot 0 carries the previous frame's LSB, so it reads hold_q before the new latch lands.
    always_comb begin
        bit_nxt = (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + CNT_W'(1);
        if (bit_nxt == '0) begin
            slot_idx = '0;
        end else if (int'(bit_nxt) <= SAMPLE_W) begin
            slot_idx = IDX_W'(SAMPLE_W - int'(bit_nxt));
        end else begin
            slot_idx = IDX_W'(2 * SAMPLE_W - int'(bit_nxt));
        end
    end

    always_comb begin
        div_cnt_d    = div_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        bclk_d       = bclk_q;
        lrclk_d      = lrclk_q;
        dacdat_d     = dacdat_q;
        hold_d       = hold_q;
        sample_req_d = 1'b0;
        if (!en) begin
            div_cnt_d = '0;
            bit_cnt_d = CNT_LAST;
            bclk_d    = 1'b0;
            lrclk_d   = 1'b1;
            dacdat_d  = 1'b0;
            hold_d    = '0;
        end else begin
            div_cnt_d = term_cnt ? '0 : div_cnt_q + DIV_W'(1);
            if (term_cnt) begin
                bclk_d = ~bclk_q;
                // bclk_q high at terminal count means this toggle is a falling edge.
                if (bclk_q) begin
                    bit_cnt_d    = bit_nxt;
                    lrclk_d      = (bit_nxt >= CNT_RIGHT);
                    dacdat_d     = hold_q[slot_idx];
                    sample_req_d = (bit_nxt == CNT_LAST);
                    if (bit_nxt == '0) begin
                        hold_d = latch_val;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q    <= '0;
            bit_cnt_q    <= CNT_LAST;
            bclk_q       <= 1'b0;
            lrclk_q      <= 1'b1;
            dacdat_q     <= 1'b0;
            sample_req_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            bclk_q       <= bclk_d;
            lrclk_q      <= lrclk_d;
            dacdat_q     <= dacdat_d;
            sample_req_q <= sample_req_d;
            hold_q       <= hold_d;
        end
    end

    assign bclk       = bclk_q;
    assign lrclk      = lrclk_q;
    assign dacdat     = dacdat_q;
    assign sample_req = sample_req_q;

endmodule

// File: tb/tb_i2s_tx.sv
// tb/tb_i2s_tx.sv - self-checking bench for i2s_tx against an arithmetic frame/slot model
// Define I2S_TX_MUTE_EN to also exercise the mute input.
module tb_i2s_tx;

    localparam int D = 8;
    localparam int W = 32;

    logic         clk;
    logic         reset_n;
    logic         en;
    logic [W-1:0] sample;
    logic         sample_req;
    logic         bclk;
    logic         lrclk;
    logic         dacdat;
`ifdef I2S_TX_MUTE_EN
    logic         mute;
`endif

    i2s_tx #(
        .BCLK_DIV(D),
        .SAMPLE_W(W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
`ifdef I2S_TX_MUTE_EN
        .mute      (mute),
`endif
        .sample    (sample),
        .sample_req(sample_req),
        .bclk      (bclk),
        .lrclk     (lrclk),
        .dacdat    (dacdat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int e = 0;
    logic [W-1:0] fs [0:15];
    logic [W-1:0] rx = '0;
    logic [W-1:0] last_left = '0;
    logic [W-1:0] last_right = '0;
    logic prev_bclk = 1'b0;
    logic prev_lr = 1'b1;
    int release_cyc = 0;
    int first_fall_pending = 0;
    int first_fall_delay = 0;
    int last_rise_cyc = -1;
    int last_lrf_cyc = -1;
    int last_req_cyc = -100000;
    int bclk_period = 0;
    int lr_period = 0;
    int req_to_fall = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic int slot_edge(input int f, input int s);
        return 2 * D * (2 * W * f + s + 1);
    endfunction

    task automatic begin_run();
        release_cyc = cyc;
        first_fall_pending = 1;
        last_rise_cyc = -1;
        last_lrf_cyc = -1;
        bclk_period = 0;
        lr_period = 0;
    endtask

    // One clk: the model counts edges since release/enable and derives every output from that count.
    task automatic step();
        logic [W-1:0] applied;
        logic live;
        int m, s, f;
        logic exp_bclk, exp_lr, exp_dat, exp_req;
`ifdef I2S_TX_MUTE_EN
        applied = mute ? '0 : sample;
`else
        applied = sample;
`endif
        live = reset_n && en;
        @(posedge clk);
        #1;
        cyc++;
        e = live ? e + 1 : 0;
        m = e / (2 * D);
        s = (m > 0) ? (m - 1) % (2 * W) : 0;
        f = (m > 0) ? (m - 1) / (2 * W) : 0;
        exp_bclk = ((e / D) % 2) == 1;
        exp_lr = 1'b1;
        exp_dat = 1'b0;
        exp_req = 1'b0;
        if (m > 0) begin
            if ((e % (2 * D)) == 0 && s == 0) fs[f] = applied;
            exp_lr = (s >= W);
            exp_req = ((e % (2 * D)) == 0) && (s == 2 * W - 1);
            if (s == 0) exp_dat = (f == 0) ? 1'b0 : fs[f-1][0];
            else if (s <= W) exp_dat = fs[f][W-s];
            else exp_dat = fs[f][2*W-s];
        end
        check("bclk", bclk, exp_bclk);
        check("lrclk", lrclk, exp_lr);
        check("dacdat", dacdat, exp_dat);
        check("sample_req", sample_req, exp_req);
        if (!prev_bclk && bclk) begin
            rx = {rx[W-2:0], dacdat};
            if (last_rise_cyc >= 0) bclk_period = cyc - last_rise_cyc;
            last_rise_cyc = cyc;
            if (m > 0 && s == W) begin
                last_left = rx;
                check("left_word", rx, fs[f]);
            end
            if (m > 0 && s == 0 && f > 0) begin
                last_right = rx;
                check("right_word", rx, fs[f-1]);
            end
        end
        if (prev_lr && !lrclk) begin
            if (first_fall_pending != 0) begin
                first_fall_delay = cyc - release_cyc;
                first_fall_pending = 0;
            end
            if (last_lrf_cyc >= 0) lr_period = cyc - last_lrf_cyc;
            last_lrf_cyc = cyc;
            req_to_fall = cyc - last_req_cyc;
        end
        if (sample_req) last_req_cyc = cyc;
        prev_bclk = bclk;
        prev_lr = lrclk;
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (e < target && guard < 20000) begin
            step();
            guard++;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        en = 1'b0;
        sample = '0;
`ifdef I2S_TX_MUTE_EN
        mute = 1'b0;
`endif
        #1;
        repeat (3) step();
        check("rst_bclk", bclk, 1'b0);
        check("rst_lrclk", lrclk, 1'b1);
        check("rst_dacdat", dacdat, 1'b0);
        check("rst_sample_req", sample_req, 1'b0);

        reset_n = 1'b1;
        en = 1'b1;
        sample = 32'hA5A5_0F0F;
        begin_run();
        run_to(slot_edge(1, 1));
        check("first_lrclk_fall", first_fall_delay, 2 * D);
        check("bclk_period", bclk_period, 2 * D);
        check("lrclk_period", lr_period, 2 * D * 2 * W);
        check("req_to_lrclk_fall", req_to_fall, 2 * D);
        check("const_left", last_left, 32'hA5A5_0F0F);
        check("const_right", last_right, 32'hA5A5_0F0F);

        sample = 32'h0000_0001;
        run_to(slot_edge(2, 10));
        sample = 32'hFFFF_FFFF;
        run_to(slot_edge(2, W + 1));
        check("midchange_cur_left", last_left, 32'h0000_0001);
        run_to(slot_edge(3, W + 1));
        check("midchange_cur_right", last_right, 32'h0000_0001);
        check("midchange_next_left", last_left, 32'hFFFF_FFFF);

        for (int k = 0; k < 4; k++) begin
            run_to(slot_edge(4 + k, $urandom_range(0, 2 * W - 1)) + $urandom_range(0, 2 * D - 1));
            sample = $urandom;
            run_to(e + $urandom_range(1, 2 * D * W));
            sample = $urandom;
        end
        run_to(slot_edge(8, 1));

        run_to(slot_edge(8, 40));
        en = 1'b0;
        step();
        check("en_off_bclk", bclk, 1'b0);
        check("en_off_lrclk", lrclk, 1'b1);
        check("en_off_dacdat", dacdat, 1'b0);
        repeat (5) step();
        en = 1'b1;
        sample = $urandom;
        begin_run();
        run_to(slot_edge(1, 1));
        check("reen_first_lrclk_fall", first_fall_delay, 2 * D);
        check("reen_bclk_period", bclk_period, 2 * D);
        check("reen_lrclk_period", lr_period, 2 * D * 2 * W);

        run_to(slot_edge(1, 20) + 3);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_bclk", bclk, 1'b0);
        check("async_rst_lrclk", lrclk, 1'b1);
        check("async_rst_dacdat", dacdat, 1'b0);
        check("async_rst_sample_req", sample_req, 1'b0);
        repeat (3) step();
        reset_n = 1'b1;
        sample = $urandom;
        begin_run();
        run_to(slot_edge(1, 1));
        check("rerst_first_lrclk_fall", first_fall_delay, 2 * D);

`ifdef I2S_TX_MUTE_EN
        sample = 32'h7FFF_0000;
        run_to(slot_edge(2, 5));
        mute = 1'b1;
        run_to(slot_edge(3, W + 1));
        check("mute_cur_right", last_right, 32'h7FFF_0000);
        check("mute_next_left", last_left, 32'h0000_0000);
        run_to(slot_edge(4, 1));
        check("mute_next_right", last_right, 32'h0000_0000);
        mute = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
